seven_seg_reader: RTL

- Reads back a multiplexed two-digit seven-segment display bus (segment lines plus per-digit select) and recovers the displayed decimal digits.
- Used as an on-board monitor and self-check for the two-digit counter's display path.
- Filters multiplex glitches by requiring a stable pattern before capture.
- Flags illegal patterns and produces a registered binary value 0..99.

---
 rtl/seven_seg_reader_if.sv | 24 ++
 rtl/seven_seg_reader.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/seven_seg_reader_if.sv
// Two-digit multiplexed seven-segment readback bus: display lines in, decoded digits out.
interface seven_seg_reader_if;
  logic [6:0] seg;
  logic [1:0] sel;
  logic       err_clr;
  logic [3:0] digit0;
  logic [3:0] digit1;
  logic       blank0;
  logic       blank1;
  logic       update;
  logic [6:0] value;
  logic       value_valid;
  logic       err;

  modport master (
    output seg, sel, err_clr,
    input  digit0, digit1, blank0, blank1, update, value, value_valid, err
  );

  modport slave (
    input  seg, sel, err_clr,
    output digit0, digit1, blank0, blank1, update, value, value_valid, err
  );
endinterface

// File: rtl/seven_seg_reader.sv
// Recovers two BCD digits from a multiplexed seven-segment bus once the pattern has
// been stable for STABLE_CYCLES edges, and publishes their binary value 0..99.
module seven_seg_reader #(
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 8
) (
  input  logic               clk,
  input  logic               reset,
  seven_seg_reader_if.slave  bus
);

  typedef enum logic [0:0] {HOLD, SETTLE} state_t;

  typedef struct packed {
    logic       legal;
    logic       blank;
    logic [3:0] digit;
  } decode_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  function automatic decode_t decode_seg(input logic [6:0] s);
    decode_t d;
    d = '{legal: 1'b1, blank: 1'b0, digit: 4'd0};
    case (s)
      7'b0111111: d.digit = 4'd0;
      7'b0000110: d.digit = 4'd1;
      7'b1011011: d.digit = 4'd2;
      7'b1001111: d.digit = 4'd3;
      7'b1100110: d.digit = 4'd4;
      7'b1101101: d.digit = 4'd5;
      7'b1111101: d.digit = 4'd6;
      7'b0000111: d.digit = 4'd7;
      7'b1111111: d.digit = 4'd8;
      7'b1101111: d.digit = 4'd9;
      7'b0000000: d.blank = 1'b1;
      default:    d.legal = 1'b0;
    endcase
    return d;
  endfunction

  // Digits are at most 9 and blanks are stored as 0, so the sum never exceeds 99.
  function automatic logic [6:0] to_value(input logic [3:0] tens, input logic [3:0] ones);
    return 7'(tens) * 7'd10 + 7'(ones);
  endfunction

  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             change;
  logic             capture;

  logic [6:0]       seg_p0;
  logic [1:0]       sel_p0;
  decode_t          dec_p0;
  logic             sel_ok_p0;
  logic             err_set_p0;

  logic [3:0]       digit0_p1;
  logic [3:0]       digit1_p1;
  logic             blank0_p1;
  logic             blank1_p1;
  logic             vld_p1;
  logic             err_p1;

  logic [6:0]       value_p2;
  logic             vld_p2;

  assign change = {bus.sel, bus.seg} != {sel_p0, seg_p0};

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= HOLD;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // A change seen on the capture edge restarts the settle window instead of capturing.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    if (change) begin
      state_d = SETTLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        SETTLE: begin
          if (cnt_q == CNT_LAST) begin
            capture = 1'b1;
            state_d = HOLD;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        HOLD:    state_d = HOLD;
        default: state_d = HOLD;
      endcase
    end
  end

  always_comb begin
    dec_p0     = decode_seg(seg_p0);
    sel_ok_p0  = (sel_p0 == 2'b01) || (sel_p0 == 2'b10);
    err_set_p0 = capture && sel_ok_p0 && !dec_p0.legal;
  end

  // p0 -> p1: sample the bus and commit decoded digits on a legal capture
  always_ff @(posedge clk) begin
    if (reset) begin
      seg_p0    <= '0;
      sel_p0    <= '0;
      digit0_p1 <= '0;
      digit1_p1 <= '0;
      blank0_p1 <= 1'b0;
      blank1_p1 <= 1'b0;
      vld_p1    <= 1'b0;
      err_p1    <= 1'b0;
    end else begin
      seg_p0 <= bus.seg;
      sel_p0 <= bus.sel;
      vld_p1 <= 1'b0;
      if (capture && sel_ok_p0 && dec_p0.legal) begin
        vld_p1 <= 1'b1;
        if (sel_p0 == 2'b01) begin
          digit0_p1 <= dec_p0.digit;
          blank0_p1 <= dec_p0.blank;
        end else begin
          digit1_p1 <= dec_p0.digit;
          blank1_p1 <= dec_p0.blank;
        end
      end
      err_p1 <= err_set_p0 | (err_p1 & ~bus.err_clr);
    end
  end

  // p1 -> p2: binary value refreshed one edge after each capture
  always_ff @(posedge clk) begin
    if (reset) begin
      value_p2 <= '0;
      vld_p2   <= 1'b0;
    end else begin
      vld_p2 <= vld_p1;
      if (vld_p1) begin
        value_p2 <= to_value(digit1_p1, digit0_p1);
      end
    end
  end

  assign bus.digit0      = digit0_p1;
  assign bus.digit1      = digit1_p1;
  assign bus.blank0      = blank0_p1;
  assign bus.blank1      = blank1_p1;
  assign bus.update      = vld_p1;
  assign bus.err         = err_p1;
  assign bus.value       = value_p2;
  assign bus.value_valid = vld_p2;

endmodule
